// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// PhaseSequencer (module phase_sequencer)
//
// Three-phase six-step (120 degree conduction) gate sequencer for the inverter
// bridge. Each one-cycle tick from the step timer advances the commutation
// step. Every commutation is preceded by a dead-time window of DEAD_CYCLES
// clocks with all six gates off, so a leg's high and low switches never
// overlap while the power devices turn off.
//
// Ports:
//   clkSignal  - system clock, rising-edge active
//   RST        - asynchronous reset, active-high
//   EN         - run enable, sampled synchronously; low turns the bridge off
//   tick       - step-advance pulse from the step timer (one cycle wide)
//   dir        - 0 = forward (step+1), 1 = reverse (step-1); sampled on tick
//   gates      - {AH,AL,BH,BL,CH,CL} gate drives, active-high, registered
//   step       - current commutation step 0..5
//   stepStrobe - one-cycle pulse when a new gate pattern is applied
//   overrun    - sticky flag: a tick arrived during dead time
// ---------------------------------------------------------------------------
module phase_sequencer #(
  parameter int DEAD_CYCLES = 8,
  parameter int DEAD_W      = 8
) (
  input  logic       clkSignal,
  input  logic       RST,
  input  logic       EN,
  input  logic       tick,
  input  logic       dir,
  output logic [5:0] gates,
  output logic [2:0] step,
  output logic       stepStrobe,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } seqState;

  // The counter is loaded one short so that DEAD lasts exactly DEAD_CYCLES
  // clocks, including the cycle in which it reaches zero.
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  seqState           state;
  logic [DEAD_W-1:0] deadCount;
  logic [2:0]        stepNext;

  // Gate pattern for each step. Every entry has exactly one high-side and
  // one low-side switch on, in different legs; an out-of-range step maps to
  // all-off so a corrupted step can never produce a shoot-through pattern.
  function automatic logic [5:0] patternFor(input logic [2:0] s);
    case (s)
      3'd0:    patternFor = 6'b100100;  // AH, BL
      3'd1:    patternFor = 6'b100001;  // AH, CL
      3'd2:    patternFor = 6'b001001;  // BH, CL
      3'd3:    patternFor = 6'b011000;  // BH, AL
      3'd4:    patternFor = 6'b010010;  // CH, AL
      3'd5:    patternFor = 6'b000110;  // CH, BL
      default: patternFor = 6'b000000;
    endcase
  endfunction

  // Step to commit on the next tick: modulo-6 increment or decrement
  // depending on the direction seen in the tick cycle.
  always_comb begin
    stepNext = step;
    if (dir) begin
      stepNext = (step == 3'd0) ? 3'd5 : step - 3'd1;
    end else begin
      stepNext = (step >= 3'd5) ? 3'd0 : step + 3'd1;
    end
  end

  // Sequencer FSM with all outputs registered. EN low overrides everything,
  // including a coincident tick, and returns the bridge to a clean idle.
  // Gates are zero in every path except DRIVE and the DEAD->DRIVE handover,
  // which is what guarantees the full dead window between any two patterns.
  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      gates      <= 6'b000000;
      step       <= 3'd0;
      stepStrobe <= 1'b0;
      overrun    <= 1'b0;
      deadCount  <= '0;
    end else begin
      stepStrobe <= 1'b0;
      if (!EN) begin
        state     <= IDLE;
        gates     <= 6'b000000;
        step      <= 3'd0;
        overrun   <= 1'b0;
        deadCount <= '0;
      end else begin
        case (state)
          IDLE: begin
            gates     <= 6'b000000;
            step      <= 3'd0;
            deadCount <= DEAD_LOAD;
            state     <= DEAD;
          end
          DEAD: begin
            gates <= 6'b000000;
            if (tick) begin
              overrun <= 1'b1;
            end
            if (deadCount == '0) begin
              gates      <= patternFor(step);
              stepStrobe <= 1'b1;
              state      <= DRIVE;
            end else begin
              deadCount <= deadCount - 1'b1;
            end
          end
          DRIVE: begin
            gates <= patternFor(step);
            if (tick) begin
              gates     <= 6'b000000;
              step      <= stepNext;
              deadCount <= DEAD_LOAD;
              state     <= DEAD;
            end
          end
          default: begin
            gates <= 6'b000000;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
